// File: rtl/press_classifier.sv
// ---------------------------------------------------------------------------
// press_classifier
//
// Classifies presses of a single debounced button into short, long and
// double presses. Time is measured in prescaler ticks (one tick every
// 2^TICK_N clk cycles), so the hold and gap thresholds scale with TICK_N.
//
// Parameters
//   TICK_N      prescaler width; one tick per 2^TICK_N clk cycles
//   LONG_TICKS  ticks of continuous hold that make a long press (2..255)
//   DBL_TICKS   longest release gap, in ticks, still counted as a double
//               press (2..255)
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   db         debounced button level, synchronous to clk
//   short_p    one-cycle pulse: single short press classified
//   long_p     one-cycle pulse: long-press threshold reached
//   double_p   one-cycle pulse: double press classified
//   held       level, high while the button is held past the long threshold
//   press_cnt  number of db rising edges seen, modulo 256
// ---------------------------------------------------------------------------
module press_classifier #(
  parameter int TICK_N     = 13,
  parameter int LONG_TICKS = 100,
  parameter int DBL_TICKS  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db,
  output logic       short_p,
  output logic       long_p,
  output logic       double_p,
  output logic       held,
  output logic [7:0] press_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam logic [7:0] LONG_LIM = 8'(LONG_TICKS);
  localparam logic [7:0] DBL_LIM  = 8'(DBL_TICKS);
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  logic [TICK_N-1:0] presc;
  logic              tick;
  logic              db_prev;
  logic              rise;
  logic              fall;
  logic [7:0]        cnt;
  state_t            state;

  // The tick is decoded from the prescaler itself, so it is high for
  // exactly the one cycle in which the counter sits at all-ones.
  assign tick = &presc;
  assign rise = db & ~db_prev;
  assign fall = ~db & db_prev;

  // Free-running prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else begin
      presc <= presc + TICK_N'(1);
    end
  end

  // Previous button level for edge detection. It resets to 0, so a button
  // already held when reset releases is seen as a fresh press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_prev <= 1'b0;
    end else begin
      db_prev <= db;
    end
  end

  // Press counter runs independently of the classifier state and simply
  // wraps at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_cnt <= 8'd0;
    end else if (rise) begin
      press_cnt <= press_cnt + 8'd1;
    end
  end

  // Classifier FSM together with its hold/gap counter and registered
  // outputs. The counter advances on ticks and saturates; any branch that
  // changes state clears it afterwards, which overrides the increment.
  // Pulses default to 0 every cycle, so each one lasts exactly one cycle and
  // only the transition that sets it can make it high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      short_p  <= 1'b0;
      long_p   <= 1'b0;
      double_p <= 1'b0;
      held     <= 1'b0;
    end else begin
      short_p  <= 1'b0;
      long_p   <= 1'b0;
      double_p <= 1'b0;
      held     <= 1'b0;

      if (tick && (cnt != CNT_MAX)) begin
        cnt <= cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= 8'd0;
          end
        end

        // Releasing on the very cycle the threshold is reached still counts
        // as a short press: fall is tested first.
        PRESS1: begin
          if (fall) begin
            state <= WAIT2;
            cnt   <= 8'd0;
          end else if (cnt == LONG_LIM) begin
            state  <= LONG_HOLD;
            cnt    <= 8'd0;
            long_p <= 1'b1;
            held   <= 1'b1;
          end
        end

        // A second press arriving on the timeout cycle still makes a double
        // press: rise is tested first.
        WAIT2: begin
          if (rise) begin
            state <= PRESS2;
            cnt   <= 8'd0;
          end else if (cnt == DBL_LIM) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            short_p <= 1'b1;
          end
        end

        // The second press of a double is not timed, so holding it long
        // never turns into a long press.
        PRESS2: begin
          if (fall) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            double_p <= 1'b1;
          end
        end

        // A press that went long ends silently on release.
        LONG_HOLD: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            held <= 1'b1;
          end
        end

        // Unused encodings fall back to IDLE without emitting anything.
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_press_classifier
//
// Self-checking bench for press_classifier with TICK_N=2, LONG_TICKS=5,
// DBL_TICKS=3 (one tick every 4 cycles). A table of button waveforms with
// expected pulse counts and latencies is run first, followed by hand-written
// sequences for reset during a hold and press counter wrap, then a random
// burst phase. Every cycle is also compared against a timestamp-based
// reference model of the press rules.
// ---------------------------------------------------------------------------
module tb_press_classifier;

  localparam int TICK_N     = 2;
  localparam int LONG_TICKS = 5;
  localparam int DBL_TICKS  = 3;
  localparam int PERIOD     = 1 << TICK_N;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       db = 1'b0;
  logic       short_p;
  logic       long_p;
  logic       double_p;
  logic       held;
  logic [7:0] press_cnt;

  press_classifier #(
    .TICK_N    (TICK_N),
    .LONG_TICKS(LONG_TICKS),
    .DBL_TICKS (DBL_TICKS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .db       (db),
    .short_p  (short_p),
    .long_p   (long_p),
    .double_p (double_p),
    .held     (held),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: tracks which part of a press gesture the button is in
  // and the cycle at which that part began. Elapsed ticks are computed from
  // cycle timestamps rather than kept as a running counter.
  typedef enum {PH_IDLE, PH_FIRST, PH_GAP, PH_SECOND, PH_LONG} phase_t;

  phase_t m_phase;
  int     m_cyc;
  int     m_entry;
  bit     m_prev;
  int     m_pcnt;
  bit     e_short, e_long, e_dbl, e_held;

  int n_short, n_long, n_dbl;
  int first_pulse_cyc;
  int long_cyc;

  typedef struct {
    string name;
    int    seg[6];
    int    exp_short;
    int    exp_long;
    int    exp_dbl;
    int    exp_cnt;
    int    ref_seg;
    int    lat_min;
    int    lat_max;
  } vec_t;

  vec_t vecs[$];

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_cyc   = 0;
    m_entry = 0;
    m_prev  = 1'b0;
    m_pcnt  = 0;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_dbl   = 1'b0;
    e_held  = 1'b0;
  endtask

  task automatic model_enter(input phase_t p);
    m_phase = p;
    m_entry = m_cyc + 1;
  endtask

  task automatic model_step(input bit d);
    bit r, f;
    int elapsed;
    r = d && !m_prev;
    f = !d && m_prev;
    // ticks fall on cycles c with c mod PERIOD == PERIOD-1; count those in
    // [m_entry, m_cyc-1]
    elapsed = m_cyc / PERIOD - m_entry / PERIOD;
    if (elapsed > 255) elapsed = 255;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_dbl   = 1'b0;
    if (r) m_pcnt = (m_pcnt + 1) % 256;
    case (m_phase)
      PH_IDLE:   if (r) model_enter(PH_FIRST);
      PH_FIRST: begin
        if (f) model_enter(PH_GAP);
        else if (elapsed == LONG_TICKS) begin
          model_enter(PH_LONG);
          e_long = 1'b1;
        end
      end
      PH_GAP: begin
        if (r) model_enter(PH_SECOND);
        else if (elapsed == DBL_TICKS) begin
          model_enter(PH_IDLE);
          e_short = 1'b1;
        end
      end
      PH_SECOND: begin
        if (f) begin
          model_enter(PH_IDLE);
          e_dbl = 1'b1;
        end
      end
      PH_LONG:   if (f) model_enter(PH_IDLE);
      default:   model_enter(PH_IDLE);
    endcase
    m_prev = d;
    m_cyc++;
    e_held = (m_phase == PH_LONG);
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    if (short_p !== e_short || long_p !== e_long || double_p !== e_dbl ||
        held !== e_held || press_cnt !== 8'(m_pcnt)) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got short=%b long=%b double=%b held=%b cnt=%0d, expected short=%b long=%b double=%b held=%b cnt=%0d",
               tag, m_cyc, short_p, long_p, double_p, held, press_cnt,
               e_short, e_long, e_dbl, e_held, m_pcnt);
    end
    if (short_p === 1'b1) n_short++;
    if (long_p === 1'b1) begin
      n_long++;
      long_cyc = m_cyc;
    end
    if (double_p === 1'b1) n_dbl++;
    if ((short_p | long_p | double_p) === 1'b1 && first_pulse_cyc < 0)
      first_pulse_cyc = m_cyc;
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic clear_tallies();
    n_short = 0;
    n_long  = 0;
    n_dbl   = 0;
    first_pulse_cyc = -1;
    long_cyc = -1;
  endtask

  // Drive one cycle of db, advance the model, and compare after the edge.
  task automatic applyStimulus(input bit d, input string tag);
    db = d;
    model_step(d);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Assert reset between edges, check the asynchronous clear, hold for n
  // edges, then release; the following cycle is model cycle 0.
  task automatic do_reset(input int n, input bit d);
    db = d;
    reset = 1'b1;
    model_reset();
    #1;
    checkOutput("reset_async");
    repeat (n) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold");
    end
    reset = 1'b0;
  endtask

  task automatic add_vec(input string name, input int s0, input int s1, input int s2,
                         input int s3, input int s4, input int s5,
                         input int es, input int el, input int ed, input int ec,
                         input int rs, input int lmin, input int lmax);
    vec_t v;
    v.name = name;
    v.seg[0] = s0; v.seg[1] = s1; v.seg[2] = s2;
    v.seg[3] = s3; v.seg[4] = s4; v.seg[5] = s5;
    v.exp_short = es;
    v.exp_long  = el;
    v.exp_dbl   = ed;
    v.exp_cnt   = ec;
    v.ref_seg   = rs;
    v.lat_min   = lmin;
    v.lat_max   = lmax;
    vecs.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit lvl;
    int ref_cyc;

    // Segments alternate high/low starting high; each entry starts from reset.
    //        name              seg0 seg1 seg2 seg3 seg4 seg5  s  l  d  cnt ref lo hi
    add_vec("short",             8,  20,   0,   0,   0,   0,  1, 0, 0, 1,  1, 12, 16);
    add_vec("long",             40,  10,   0,   0,   0,   0,  0, 1, 0, 1,  0, 20, 24);
    add_vec("double",            6,   4,   6,  10,   0,   0,  0, 0, 1, 2,  3,  1,  1);
    add_vec("slow_double",       6,  20,   6,  20,   0,   0,  2, 0, 0, 2, -1,  0,  0);
    add_vec("triple",            4,   3,   4,   3,   4,  20,  1, 0, 1, 3, -1,  0,  0);
    add_vec("long_second",       6,   3,  60,   5,   0,   0,  0, 0, 1, 2, -1,  0,  0);
    add_vec("gap_rise_at_limit", 8,  12,   6,  10,   0,   0,  0, 0, 1, 2, -1,  0,  0);
    add_vec("gap_rise_late",     8,  13,   6,  20,   0,   0,  2, 0, 0, 2, -1,  0,  0);
    add_vec("fall_at_limit",    20,  20,   0,   0,   0,   0,  1, 0, 0, 1, -1,  0,  0);
    add_vec("hold_to_limit",    21,  10,   0,   0,   0,   0,  0, 1, 0, 1, -1,  0,  0);

    clear_tallies();
    model_reset();
    #1;
    checkOutput("reset_initial");

    foreach (vecs[i]) begin
      do_reset(2, 1'b0);
      clear_tallies();
      ref_cyc = -1;
      lvl = 1'b1;
      for (int s = 0; s < 6; s++) begin
        if (s == vecs[i].ref_seg) ref_cyc = m_cyc;
        for (int c = 0; c < vecs[i].seg[s]; c++) applyStimulus(lvl, vecs[i].name);
        lvl = !lvl;
      end
      check_int({vecs[i].name, "_short"}, n_short, vecs[i].exp_short);
      check_int({vecs[i].name, "_long"}, n_long, vecs[i].exp_long);
      check_int({vecs[i].name, "_double"}, n_dbl, vecs[i].exp_dbl);
      check_int({vecs[i].name, "_press_cnt"}, int'(press_cnt), vecs[i].exp_cnt);
      if (vecs[i].ref_seg >= 0)
        check_range({vecs[i].name, "_latency"}, first_pulse_cyc - ref_cyc,
                    vecs[i].lat_min, vecs[i].lat_max);
    end

    // Reset in the middle of a hold, button kept high through it.
    do_reset(2, 1'b0);
    clear_tallies();
    for (int c = 0; c < 15; c++) applyStimulus(1'b1, "mid_hold_pre");
    do_reset(3, 1'b1);
    clear_tallies();
    applyStimulus(1'b1, "mid_hold_post");
    check_int("mid_hold_press_cnt", int'(press_cnt), 1);
    for (int c = 0; c < 29; c++) applyStimulus(1'b1, "mid_hold_post");
    check_int("mid_hold_long", n_long, 1);
    check_range("mid_hold_long_latency", long_cyc, 20, 24);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, "mid_hold_release");
    check_int("mid_hold_no_short", n_short, 0);

    // 256 short presses bring the press counter back to zero.
    do_reset(2, 1'b0);
    clear_tallies();
    for (int p = 0; p < 256; p++) begin
      for (int c = 0; c < 3; c++) applyStimulus(1'b1, "wrap");
      for (int c = 0; c < 16; c++) applyStimulus(1'b0, "wrap");
    end
    check_int("wrap_short_count", n_short, 256);
    check_int("wrap_press_cnt", int'(press_cnt), 0);

    // Random bursts, occasionally interrupted by reset.
    do_reset(2, 1'b0);
    for (int b = 0; b < 80; b++) begin
      int hi_len, lo_len;
      hi_len = $urandom_range(1, 30);
      lo_len = $urandom_range(1, 20);
      for (int c = 0; c < hi_len; c++) applyStimulus(1'b1, "random");
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 3), $urandom_range(0, 1) == 1);
      for (int c = 0; c < lo_len; c++) applyStimulus(1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
